// File: rtl/adder_seq_ctrl_pkg.sv
// Shared definitions for the sequential multi-byte adder controller:
// controller state encoding and the datapath byte width.
package adder_seq_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_seq_ctrl_adder8B.sv
// Byte-wide adder built from two nibble stages; entAcarreo feeds the low
// nibble so a carry can be chained in from the previous byte.
module adder8B (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       entAcarreo,
  output logic [7:0] sum,
  output logic       salAcarreo
);

  logic [4:0] w_lo;
  logic [4:0] w_hi;

  assign w_lo = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, entAcarreo};
  assign w_hi = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0000, w_lo[4]};

  assign sum        = {w_hi[3:0], w_lo[3:0]};
  assign salAcarreo = w_hi[4];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Sequential W-bit adder: walks one shared adder8B across the operand bytes,
// LSB first, with the inter-byte carry held in a flop between cycles.
module adder_seq_ctrl
  import adder_seq_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inicio,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                entAcarreo,
  output logic [8*NBYTES-1:0] sum,
  output logic                salAcarreo,
  output logic                desbordamiento,
  output logic                ocupado,
  output logic                listo
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic               r_c;
  logic               r_cout;
  logic               r_ovf;
  logic [IDX_W-1:0]   r_idx;

  logic [BYTE_W-1:0]  w_aByte;
  logic [BYTE_W-1:0]  w_bByte;
  logic [BYTE_W-1:0]  w_sumByte;
  logic               w_cout;
  logic               w_last;

  assign w_aByte = r_a[BYTE_W*r_idx +: BYTE_W];
  assign w_bByte = r_b[BYTE_W*r_idx +: BYTE_W];
  assign w_last  = (r_idx == LAST_IDX);

  adder8B u_adder (
    .a          (w_aByte),
    .b          (w_bByte),
    .entAcarreo (r_c),
    .sum        (w_sumByte),
    .salAcarreo (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (inicio) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Index wraps to 0 on the last byte so the lane selects stay in range
  // while the controller sits in DONE/IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_idx  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (inicio) begin
            r_a    <= a;
            r_b    <= b;
            r_c    <= entAcarreo;
            r_idx  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
          end
        end
        RUN: begin
          r_sum[BYTE_W*r_idx +: BYTE_W] <= w_sumByte;
          r_c   <= w_cout;
          r_idx <= w_last ? '0 : r_idx + 1'b1;
          if (w_last) begin
            r_cout <= w_cout;
            r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_sumByte[BYTE_W-1] != r_a[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum            = r_sum;
  assign salAcarreo     = r_cout;
  assign desbordamiento = r_ovf;
  assign ocupado        = (r_state == RUN);
  assign listo          = (r_state == DONE);

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl (NBYTES=4): a cycle-count reference
// model checked every cycle, plus directed vectors with literal results.
module tb_adder_seq_ctrl;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inicio;
  logic [31:0] a;
  logic [31:0] b;
  logic        entAcarreo;
  logic [31:0] sum;
  logic        salAcarreo;
  logic        desbordamiento;
  logic        ocupado;
  logic        listo;

  int total = 0;
  int bad   = 0;

  adder_seq_ctrl #(.NBYTES(NB)) dut (
    .clk            (clk),
    .rst            (rst),
    .inicio         (inicio),
    .a              (a),
    .b              (b),
    .entAcarreo     (entAcarreo),
    .sum            (sum),
    .salAcarreo     (salAcarreo),
    .desbordamiento (desbordamiento),
    .ocupado        (ocupado),
    .listo          (listo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signedOverflow(input logic [31:0] x, input logic [31:0] y, input logic c);
    longint s;
    s = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Reference model: mPhase counts edges since an accepted start (0 = idle).
  int          mPhase = 0;
  logic [31:0] mSum = '0, pSum = '0;
  logic        mCarry = 1'b0, pCarry = 1'b0;
  logic        mOvf = 1'b0, pOvf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPhase = 0;
      mSum = '0; mCarry = 1'b0; mOvf = 1'b0;
    end else if (mPhase == 0) begin
      if (inicio) begin
        {pCarry, pSum} = {1'b0, a} + {1'b0, b} + {32'd0, entAcarreo};
        pOvf   = signedOverflow(a, b, entAcarreo);
        mSum   = '0; mCarry = 1'b0; mOvf = 1'b0;
        mPhase = 1;
      end
    end else begin
      mPhase++;
      if (mPhase == NB + 1) begin
        mSum = pSum; mCarry = pCarry; mOvf = pOvf;
      end
      if (mPhase == NB + 2) mPhase = 0;
    end
  end

  always @(negedge clk) begin
    checkOutput("m_ocupado", 64'(ocupado), 64'(mPhase >= 1 && mPhase <= NB));
    checkOutput("m_listo", 64'(listo), 64'(mPhase == NB + 1));
    checkOutput("m_salAcarreo", 64'(salAcarreo), 64'(mCarry));
    checkOutput("m_desbordamiento", 64'(desbordamiento), 64'(mOvf));
    if (mPhase == 0 || mPhase == NB + 1)
      checkOutput("m_sum", 64'(sum), 64'(mSum));
  end

  // Starts one addition and waits for listo; optional noise keeps inicio high
  // with different operands throughout RUN and DONE.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                               input bit noise, output int lat, output int busy);
    @(negedge clk);
    a = av; b = bv; entAcarreo = cv; inicio = 1'b1;
    @(posedge clk);
    lat = 0; busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (noise) begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; inicio = 1'b1; end
      else inicio = 1'b0;
      if (ocupado) busy++;
      if (listo) break;
      @(posedge clk);
      lat++;
    end
    if (!listo) checkOutput("listo_timeout", 64'd0, 64'd1);
    if (noise) begin
      @(posedge clk);
      @(negedge clk);
      inicio = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, busy;
    rst = 1'b1; inicio = 1'b0; a = '0; b = '0; entAcarreo = 1'b0;
    #12;
    checkOutput("rst_sum", 64'(sum), 64'h0);
    checkOutput("rst_ocupado", 64'(ocupado), 64'h0);
    checkOutput("rst_listo", 64'(listo), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(32'h000000FF, 32'h00000001, 1'b0, 1'b0, lat, busy);
    checkOutput("t1_sum", 64'(sum), 64'h00000100);
    checkOutput("t1_cout", 64'(salAcarreo), 64'h0);
    checkOutput("t1_ovf", 64'(desbordamiento), 64'h0);
    checkOutput("t1_latency", 64'(lat), 64'd4);

    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, lat, busy);
    checkOutput("t2_sum", 64'(sum), 64'h00000000);
    checkOutput("t2_cout", 64'(salAcarreo), 64'h1);
    checkOutput("t2_ovf", 64'(desbordamiento), 64'h0);

    applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, lat, busy);
    checkOutput("t3_sum", 64'(sum), 64'h80000000);
    checkOutput("t3_cout", 64'(salAcarreo), 64'h0);
    checkOutput("t3_ovf", 64'(desbordamiento), 64'h1);

    applyStimulus(32'h12345678, 32'h11111111, 1'b1, 1'b0, lat, busy);
    checkOutput("t4_sum", 64'(sum), 64'h2345678A);
    checkOutput("t4_busy_cycles", 64'(busy), 64'd4);

    applyStimulus(32'h80000000, 32'h80000000, 1'b0, 1'b0, lat, busy);
    checkOutput("t4b_sum", 64'(sum), 64'h00000000);
    checkOutput("t4b_cout", 64'(salAcarreo), 64'h1);
    checkOutput("t4b_ovf", 64'(desbordamiento), 64'h1);

    applyStimulus(32'h00000001, 32'h00000001, 1'b0, 1'b1, lat, busy);
    checkOutput("t5_sum", 64'(sum), 64'h00000002);
    checkOutput("t5_idle", 64'(ocupado), 64'h0);
    applyStimulus(32'h00000003, 32'h00000004, 1'b0, 1'b0, lat, busy);
    checkOutput("t5_next_sum", 64'(sum), 64'h00000007);
    checkOutput("t5_next_latency", 64'(lat), 64'd4);

    @(negedge clk);
    a = 32'h0F0F0F0F; b = 32'h01010101; entAcarreo = 1'b0; inicio = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("t6_partial_sum", 64'(sum), 64'h00001010);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_sum", 64'(sum), 64'h0);
    checkOutput("t6_rst_ocupado", 64'(ocupado), 64'h0);
    checkOutput("t6_rst_listo", 64'(listo), 64'h0);
    checkOutput("t6_rst_flags", 64'({salAcarreo, desbordamiento}), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'h00000010, 32'h00000020, 1'b0, 1'b0, lat, busy);
    checkOutput("t6_sum", 64'(sum), 64'h00000030);
    checkOutput("t6_latency", 64'(lat), 64'd4);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
